tlul_xbar_nto1: RTL and testbench
=================================

# tlul_xbar_nto1

Parametrised N-host to 1-device TL-UL crossbar, successor to the fixed 2-to-1 crossbar in front of the SRAM. It arbitrates the A channel of `NumHosts` TL-UL hosts onto a single device port using fair round-robin. It tracks up to `MaxOutstanding` in-flight requests in an internal host-index FIFO and routes each D-channel response back to the host that issued the matching request. Sits between core/main/DMA hosts and a single in-order TL-UL device (SRAM, peripheral bus bridge).

## Interface
Parameters:
- `NumHosts`, 2: number of host ports; range 2..8.
- `MaxOutstanding`, 4: maximum accepted requests still awaiting a response; range 1..16.
- `HostIdxW`, `$clog2(NumHosts)`: derived localparam, not overridable.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `tl_h_i`  in  `tlul_pkg::tl_h2d_t [NumHosts]`  host requests.
- `tl_h_o`  out  `tlul_pkg::tl_d2h_t [NumHosts]`  host responses and `a_ready`.
- `tl_d_o`  out  `tlul_pkg::tl_h2d_t`  device request.
- `tl_d_i`  in  `tlul_pkg::tl_d2h_t`  device response.
- `err_o`  out  1  sticky flag: a response arrived with no outstanding request.

## Operation
- **Device contract.** The device responds strictly in request order.
- **A-channel selection.** A-channel fields of the granted host pass combinationally to `tl_d_o`, except `d_ready`, which is taken from the FIFO-head host.
  - Only the granted host sees `a_ready = tl_d_i.a_ready`; all other hosts see `a_ready = 0`.
- **Round-robin arbitration.**
  - Register `rr_ptr` holds the highest-priority host.
  - Grant goes to the first host with `a_valid` set, searching from `rr_ptr` upward with wrap.
  - On an accepted beat (`tl_d_o.a_valid && tl_d_i.a_ready`), `rr_ptr` becomes granted+1, wrapping modulo `NumHosts`.
- **Grant lock.**
  - If `tl_d_o.a_valid` is set and `a_ready` is clear, register `lock_q` is set and `lock_idx_q` holds the granted host.
  - While `lock_q` is set, grant is forced to `lock_idx_q`. Once a request is presented, it is never switched away from.
  - `lock_q` clears on acceptance.
- **ID FIFO.**
  - Each accepted beat pushes the granted index.
  - Each D handshake (`tl_d_i.d_valid && tl_d_o.d_ready`) pops it.
- **D-channel routing.**
  - `tl_d_i` fields are broadcast to all hosts; `d_valid` goes only to the FIFO-head host.
  - `tl_d_o.d_ready` is the head host's `d_ready`.
- **Full.** When the count equals `MaxOutstanding`, `tl_d_o.a_valid = 0` and all host `a_ready = 0`.
  - A pop in the same cycle does not unblock a push; there is no D-to-A combinational path.
- **Empty.** `tl_d_o.d_ready = 1`, so a stray response is sunk.
  - A stray `d_valid` sets `err_o`, which stays set until `rst_i`.
  - No host sees `d_valid`.
- **Simultaneous push and pop** (count below full): count is unchanged and both pointers advance.

## Timing
- **Request latency.** Host `a_valid` to device `a_valid` is 0 cycles (combinational), given no lock on another host and FIFO not full.
- **Response latency.** Device `d_valid` to host `d_valid` is 0 cycles.
- **Registered state.** `rr_ptr`, `lock_q`, `lock_idx_q`, FIFO storage, rd/wr pointers, count and `err_o` are all registered and updated on `clk_i` rising edge.
- **Reset values** (`rst_i` sampled high):
  - `rr_ptr = 0`, `lock_q = 0`, count = 0, pointers = 0, `err_o = 0`.
  - While `rst_i` is high: `tl_d_o.a_valid = 0`, all host `a_ready = 0`, all host `d_valid = 0`, `tl_d_o.d_ready = 0`.
- **Reset mid-transaction.** Outstanding entries are discarded. Responses arriving after reset are treated as stray.
- **Pointer wrap.** Pointers wrap at `MaxOutstanding`; a non-power-of-2 depth uses an explicit compare, not bit truncation.

## Structure
- **Package `tlul_xbar_nto1_pkg`.** Holds the `NumHosts`/`MaxOutstanding` range-check constants and the `rr_next` function (masked round-robin search).
- **Sub-module `tlul_xbar_nto1_idfifo`.** Synchronous FIFO, width `HostIdxW` and depth `MaxOutstanding`, with `push`/`pop`/`full`/`empty`/`head`. Uses the same `clk_i`/`rst_i`.
- **Top module.** Contains the arbiter, lock logic, muxing and `err_o`.

## Test plan
- **Single host:** `NumHosts=4`, host 2 writes addr 0x100 data 0x100, device `a_ready=1`.
  - Device sees addr 0x100 in the same cycle; the response returns only to host 2; `err_o = 0`.
- **Fairness:** all 4 hosts hold `a_valid` with distinct addrs 0x10, 0x20, 0x30, 0x40, device always ready.
  - Grants go 0,1,2,3,0 on consecutive cycles; responses are routed in the same order.
- **Lock:** host 1 valid and device `a_ready = 0` for 3 cycles, then host 0 raises valid.
  - Device keeps seeing host 1's addr unchanged until accepted; host 0 is granted the next cycle.
- **Full:** `MaxOutstanding=2`, device withholds responses, 3 hosts request.
  - Exactly 2 accepted; device `a_valid = 0` until one response pops; the third is accepted the cycle after the pop.
- **Stray response:** FIFO empty, device drives `d_valid` for 1 cycle.
  - `d_ready = 1`; no host `d_valid`; `err_o` becomes 1 and stays set until `rst_i`.
- **Reset mid-flight:** 2 outstanding, `rst_i` pulsed for 1 cycle.
  - Count is 0; a subsequent response sets `err_o`; new requests proceed starting at host 0.

Source files
------------

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL A/D channel structs shared by hosts and devices
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/tlul_xbar_nto1_pkg.sv
// tlul_xbar_nto1_pkg: parameter limits and round-robin search for the N-to-1 crossbar
package tlul_xbar_nto1_pkg;
    localparam int MinHosts            = 2;
    localparam int MaxHosts            = 8;
    localparam int MinOutstanding      = 1;
    localparam int MaxOutstandingLimit = 16;
    // Lowest requester at or above ptr wins; otherwise the lowest requester overall.
    function automatic logic [2:0] rr_next(input logic [MaxHosts-1:0] req, input logic [2:0] ptr, input int n);
        rr_next = ptr;
        for (int i = MaxHosts - 1; i >= 0; i--)
            if (req[i] && i < n) rr_next = 3'(i);
        for (int i = MaxHosts - 1; i >= 0; i--)
            if (req[i] && i < n && i >= int'(ptr)) rr_next = 3'(i);
    endfunction
endpackage

// File: rtl/tlul_xbar_nto1_idfifo.sv
// tlul_xbar_nto1_idfifo: in-order FIFO of host indices for outstanding requests
module tlul_xbar_nto1_idfifo #(
    parameter int Width = 1,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr, r_rd;
    logic [CntW-1:0]  r_cnt;
    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= inc(r_wr);
            if (pop_i) r_rd <= inc(r_rd);
            if (push_i != pop_i) r_cnt <= push_i ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= wdata_i;
    end
    assign full_o  = r_cnt == CntW'(Depth);
    assign empty_o = r_cnt == '0;
    assign head_o  = r_mem[r_rd];
endmodule

// File: rtl/tlul_xbar_nto1.sv
// tlul_xbar_nto1: round-robin N-host to 1-device TL-UL crossbar with in-order response routing
module tlul_xbar_nto1
    import tlul_xbar_nto1_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i,
    output logic              err_o
);
    localparam int HostIdxW = $clog2(NumHosts);
    if (NumHosts < MinHosts || NumHosts > MaxHosts ||
        MaxOutstanding < MinOutstanding || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_param
        $error("tlul_xbar_nto1: parameter out of range");
    end
    logic [HostIdxW-1:0] r_rr_ptr, r_lock_idx, w_grant, w_grant_nxt, w_head;
    logic                r_lock, r_err;
    logic [MaxHosts-1:0] w_req;
    logic                w_full, w_empty, w_a_valid, w_d_ready, w_accept, w_pop;
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NumHosts; i++) w_req[i] = tl_h_i[i].a_valid;
    end
    assign w_grant     = r_lock ? r_lock_idx : HostIdxW'(rr_next(w_req, 3'(r_rr_ptr), NumHosts));
    assign w_grant_nxt = (w_grant == HostIdxW'(NumHosts - 1)) ? '0 : w_grant + 1'b1;
    assign w_a_valid   = !rst_i && !w_full && tl_h_i[w_grant].a_valid;
    assign w_accept    = w_a_valid && tl_d_i.a_ready;
    // With nothing outstanding the device port sinks stray responses.
    assign w_d_ready   = !rst_i && (w_empty || tl_h_i[w_head].d_ready);
    assign w_pop       = tl_d_i.d_valid && w_d_ready && !w_empty;
    always_comb begin
        tl_d_o         = tl_h_i[w_grant];
        tl_d_o.a_valid = w_a_valid;
        tl_d_o.d_ready = w_d_ready;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = !rst_i && !w_full && w_grant == HostIdxW'(i) && tl_d_i.a_ready;
            tl_h_o[i].d_valid = !rst_i && !w_empty && w_head == HostIdxW'(i) && tl_d_i.d_valid;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) r_rr_ptr <= w_grant_nxt;
            r_lock <= w_a_valid && !tl_d_i.a_ready;
            if (w_a_valid) r_lock_idx <= w_grant;
            if (tl_d_i.d_valid && w_empty) r_err <= 1'b1;
        end
    end
    assign err_o = r_err;
    tlul_xbar_nto1_idfifo #(
        .Width(HostIdxW),
        .Depth(MaxOutstanding)
    ) u_idfifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_accept),
        .wdata_i(w_grant),
        .pop_i  (w_pop),
        .full_o (w_full),
        .empty_o(w_empty),
        .head_o (w_head)
    );
endmodule

// File: tb/tb_tlul_xbar_nto1.sv
// tb_tlul_xbar_nto1: scoreboard bench for the N-to-1 TL-UL crossbar (4 hosts, depth 2)
module tb_tlul_xbar_nto1;
    import tlul_pkg::*;
    localparam int NH = 4;
    typedef struct { int host; logic [31:0] val; } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tl_h2d_t     tl_h_i [NH];
    tl_d2h_t     tl_h_o [NH];
    tl_h2d_t     tl_d_o;
    tl_d2h_t     tl_d_i;
    logic        err;
    logic        dev_ready = 1'b1;
    logic        resp_en = 1'b1;
    logic        dev_dv = 1'b0;
    logic [31:0] dev_data = '0;
    int          passed = 0;
    int          total = 0;
    exp_t        exp_a[$];
    exp_t        exp_d[$];
    logic [31:0] hq [NH][$];
    logic [31:0] dev_q[$];

    always #5 clk = ~clk;

    tlul_xbar_nto1 #(.NumHosts(NH), .MaxOutstanding(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .tl_h_i(tl_h_i),
        .tl_h_o(tl_h_o),
        .tl_d_o(tl_d_o),
        .tl_d_i(tl_d_i),
        .err_o (err)
    );

    always_comb begin
        tl_d_i         = '0;
        tl_d_i.a_ready = dev_ready;
        tl_d_i.d_valid = dev_dv;
        tl_d_i.d_data  = dev_data;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic req(input int h, input logic [31:0] a, input bit resp);
        hq[h].push_back(a);
        exp_a.push_back('{h, a});
        if (resp) exp_d.push_back('{h, a + 1});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            cyc(1);
            idle = exp_a.size() == 0 && exp_d.size() == 0 && dev_q.size() == 0 &&
                   hq[0].size() == 0 && hq[1].size() == 0 && hq[2].size() == 0 && hq[3].size() == 0;
        end
        chk("idle_in_budget", 32'(idle), 1);
    endtask

    // Host drivers and in-order device model: sample at negedge, update just after posedge.
    initial begin
        bit          acc_h [NH];
        logic        acc, dhs;
        logic [31:0] acc_addr;
        for (int h = 0; h < NH; h++) begin
            tl_h_i[h]         = '0;
            tl_h_i[h].d_ready = 1'b1;
            tl_h_i[h].a_mask  = 4'hF;
            tl_h_i[h].a_size  = 2'd2;
        end
        forever begin
            @(negedge clk);
            for (int h = 0; h < NH; h++) acc_h[h] = tl_h_i[h].a_valid && tl_h_o[h].a_ready;
            acc      = tl_d_o.a_valid && tl_d_i.a_ready;
            acc_addr = tl_d_o.a_address;
            dhs      = tl_d_i.d_valid && tl_d_o.d_ready;
            @(posedge clk);
            #1;
            for (int h = 0; h < NH; h++) begin
                if (acc_h[h] && hq[h].size() > 0) void'(hq[h].pop_front());
                tl_h_i[h].a_valid   = hq[h].size() > 0;
                tl_h_i[h].a_address = hq[h].size() > 0 ? hq[h][0] : '0;
                tl_h_i[h].a_data    = hq[h].size() > 0 ? hq[h][0] : '0;
            end
            if (dhs && dev_q.size() > 0) void'(dev_q.pop_front());
            if (acc) dev_q.push_back(acc_addr);
            dev_dv   = resp_en && dev_q.size() > 0;
            dev_data = dev_q.size() > 0 ? dev_q[0] + 1 : '0;
        end
    end

    always @(negedge clk) begin : monitor
        int   ng, gh, nd, dh;
        exp_t e;
        if (tl_d_o.a_valid && tl_d_i.a_ready) begin
            ng = 0;
            gh = 0;
            for (int h = 0; h < NH; h++) if (tl_h_o[h].a_ready) begin ng++; gh = h; end
            chk("a_onehot_ready", 32'(ng), 1);
            chk("a_pending", 32'(exp_a.size() > 0), 1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("a_host", 32'(gh), 32'(e.host));
                chk("a_addr", tl_d_o.a_address, e.val);
                chk("a_data", tl_d_o.a_data, e.val);
            end
        end
        nd = 0;
        dh = 0;
        for (int h = 0; h < NH; h++) if (tl_h_o[h].d_valid) begin nd++; dh = h; end
        if (nd > 0) begin
            chk("d_onehot", 32'(nd), 1);
            chk("d_pending", 32'(exp_d.size() > 0), 1);
            if (exp_d.size() > 0) begin
                e = exp_d.pop_front();
                chk("d_host", 32'(dh), 32'(e.host));
                chk("d_data", tl_h_o[dh].d_data, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1);
        req(1, 32'h1C0, 1);
        cyc(1);
        chk("rst_a_valid", 32'(tl_d_o.a_valid), 0);
        chk("rst_h1_a_ready", 32'(tl_h_o[1].a_ready), 0);
        chk("rst_d_ready", 32'(tl_d_o.d_ready), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        wait_idle(20);
        // single host
        do_reset();
        req(2, 32'h100, 1);
        cyc(1);
        chk("single_a_valid", 32'(tl_d_o.a_valid), 1);
        chk("single_addr", tl_d_o.a_address, 32'h100);
        chk("single_h2_ready", 32'(tl_h_o[2].a_ready), 1);
        chk("single_h0_ready", 32'(tl_h_o[0].a_ready), 0);
        wait_idle(20);
        chk("single_err", 32'(err), 0);
        // fairness
        do_reset();
        req(0, 32'h10, 1);
        req(1, 32'h20, 1);
        req(2, 32'h30, 1);
        req(3, 32'h40, 1);
        req(0, 32'h50, 1);
        cyc(6);
        chk("fair_back_to_back", 32'(exp_a.size()), 0);
        wait_idle(20);
        // lock
        do_reset();
        dev_ready = 1'b0;
        req(1, 32'h200, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("lock_hold_valid", 32'(tl_d_o.a_valid), 1);
            chk("lock_hold_addr", tl_d_o.a_address, 32'h200);
        end
        req(0, 32'h300, 1);
        cyc(1);
        chk("lock_keep_addr", tl_d_o.a_address, 32'h200);
        chk("lock_h0_blocked", 32'(tl_h_o[0].a_ready), 0);
        dev_ready = 1'b1;
        cyc(1);
        chk("lock_next_h0_addr", tl_d_o.a_address, 32'h300);
        chk("lock_next_h0_ready", 32'(tl_h_o[0].a_ready), 1);
        wait_idle(20);
        // full
        do_reset();
        resp_en = 1'b0;
        req(0, 32'h400, 1);
        req(1, 32'h410, 1);
        req(2, 32'h420, 1);
        cyc(3);
        chk("full_two_accepted", 32'(exp_a.size()), 1);
        chk("full_a_valid", 32'(tl_d_o.a_valid), 0);
        chk("full_h2_ready", 32'(tl_h_o[2].a_ready), 0);
        cyc(1);
        chk("full_still_blocked", 32'(tl_d_o.a_valid), 0);
        resp_en = 1'b1;
        cyc(1);
        chk("full_pop_cycle_blocked", 32'(tl_d_o.a_valid), 0);
        chk("full_pop_h0_dvalid", 32'(tl_h_o[0].d_valid), 1);
        cyc(1);
        chk("full_third_valid", 32'(tl_d_o.a_valid), 1);
        chk("full_third_addr", tl_d_o.a_address, 32'h420);
        wait_idle(20);
        // stray response
        chk("stray_err_before", 32'(err), 0);
        dev_q.push_back(32'hDEAD0000);
        cyc(1);
        chk("stray_d_ready", 32'(tl_d_o.d_ready), 1);
        chk("stray_no_host", 32'({tl_h_o[3].d_valid, tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}), 0);
        cyc(1);
        chk("stray_err_set", 32'(err), 1);
        cyc(3);
        chk("stray_err_sticky", 32'(err), 1);
        // reset mid-flight
        resp_en = 1'b0;
        req(1, 32'h500, 0);
        req(2, 32'h510, 0);
        cyc(3);
        chk("mid_two_outstanding", 32'(exp_a.size()), 0);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_d_ready", 32'(tl_d_o.d_ready), 0);
        chk("mid_rst_a_valid", 32'(tl_d_o.a_valid), 0);
        rst = 1'b0;
        cyc(1);
        chk("mid_err_cleared", 32'(err), 0);
        resp_en = 1'b1;
        cyc(4);
        chk("mid_stray_err", 32'(err), 1);
        chk("mid_dev_drained", 32'(dev_q.size()), 0);
        req(1, 32'h600, 1);
        req(3, 32'h610, 1);
        wait_idle(20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
